// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter; define UART_TX_PARITY_EN to insert a parity bit
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DATA_W-1:0]             data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam state_t AFTER_DATA = PARITY;
  logic par;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level_n;
  logic [CW-1:0] baud;
  logic [3:0] bit_cnt;
  logic [DATA_W-1:0] shift;
  state_t state;
  logic push, pop, bit_end, stop_done, to_idle;
  always_comb begin
    push = valid_i && ready_o;
    bit_end = baud == LAST_CLK;
    stop_done = state == STOP && bit_end && bit_cnt == LAST_STOP;
    pop = level_o != '0 && (state == IDLE || stop_done);
    to_idle = level_o == '0 && (state == IDLE || stop_done);
    level_n = (push && !pop) ? level_o + 1'b1 : (pop && !push) ? level_o - 1'b1 : level_o;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level_o <= '0;
      ready_o <= 1'b1;
    end else begin
      if (push) mem[wr_ptr] <= data_i;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level_o <= level_n;
      ready_o <= level_n != FULL;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      shift <= '0;
      tx_o <= 1'b1;
      busy_o <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
`ifdef UART_TX_PARITY_EN
      tx_o <= state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par : 1'b1;
`else
      tx_o <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
`endif
      busy_o <= !(to_idle && level_n == '0);
      baud <= (state == IDLE || bit_end) ? '0 : baud + 1'b1;
      if (pop) begin
        shift <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
        par <= ^mem[rd_ptr] ^ 1'(PARITY_ODD);
`endif
        bit_cnt <= '0;
        state <= START;
      end else if (to_idle) begin
        state <= IDLE;
      end else if (bit_end) begin
        case (state)
          START: begin
            bit_cnt <= '0;
            state <= DATA;
          end
          DATA: begin
            shift <= shift >> 1;
            bit_cnt <= bit_cnt == LAST_DATA ? '0 : bit_cnt + 1'b1;
            if (bit_cnt == LAST_DATA) state <= AFTER_DATA;
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            bit_cnt <= '0;
            state <= STOP;
          end
`endif
          STOP: bit_cnt <= bit_cnt + 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed check of uart_tx_fifo against a frame-schedule model
module tb_uart_tx_fifo;
  localparam int DW = 8;
  localparam int C = 4;
  localparam int DEPTH = 4;
  localparam bit ODD = 1'b0;
`ifdef UART_TX_PARITY_EN
  localparam int SB = 2;
  localparam int P = 1;
`else
  localparam int SB = 1;
  localparam int P = 0;
`endif
  localparam int F = (1 + DW + P + SB) * C;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic ready, tx, busy;
  logic [2:0] level;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] q[$];
  bit m_act = 1'b0;
  bit acc;
  int m_s = 0;
  logic [7:0] m_word = 8'h00;
  logic m_tx, m_busy, m_ready;
  int m_level;
  logic hist [0:63];
  logic bh [0:63];
  int n0;
  logic [9:0] a5_line = 10'b1101001010;
  logic [7:0] burst [5] = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h55};
  uart_tx_fifo #(
    .DATA_W(DW), .CLKS_PER_BIT(C), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH), .PARITY_ODD(int'(ODD))
  ) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid),
    .ready_o(ready), .tx_o(tx), .busy_o(busy), .level_o(level)
  );
  always #5 clk = ~clk;
  function automatic logic frame_bit(input logic [7:0] w, input int k);
    if (k == 0) return 1'b0;
    if (k <= DW) return w[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == DW + 1) return ^w ^ ODD;
`endif
    return 1'b1;
  endfunction
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      m_act = 1'b0;
      m_tx = 1'b1;
      m_busy = 1'b0;
      m_ready = 1'b1;
      m_level = 0;
    end else begin
      acc = valid && m_ready;
      m_tx = m_act ? frame_bit(m_word, (cyc - 1 - m_s) / C) : 1'b1;
      if (m_act && cyc == m_s + F) m_act = 1'b0;
      if (!m_act && q.size() > 0) begin
        m_word = q.pop_front();
        m_s = cyc;
        m_act = 1'b1;
      end
      if (acc) q.push_back(data);
      m_level = q.size();
      m_ready = m_level != DEPTH;
      m_busy = m_act || m_level != 0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("tx", 32'(tx), 32'(m_tx));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("ready", 32'(ready), 32'(m_ready));
    chk("level", 32'(level), m_level);
  endtask
  task automatic push_one(input logic [7:0] w);
    valid = 1'b1;
    data = w;
    tick();
    valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 2000 && busy; i++) tick();
    chk("drain_busy", 32'(busy), 0);
    chk("drain_tx", 32'(tx), 1);
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_tx", 32'(tx), 1);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_ready", 32'(ready), 1);
      chk("idle_level", 32'(level), 0);
    end
    push_one(8'hA5);
    n0 = cyc;
    for (int i = 1; i <= F + 4; i++) begin
      tick();
      hist[i] = tx;
      bh[i] = busy;
    end
    chk("a5_latency_high", 32'(hist[1]), 1);
    chk("a5_start_low", 32'(hist[2]), 0);
`ifndef UART_TX_PARITY_EN
    for (int b = 0; b < 10; b++)
      for (int j = 0; j < C; j++)
        chk($sformatf("a5_bit%0d", b), 32'(hist[2 + C * b + j]), 32'(a5_line[b]));
`endif
    chk("a5_busy_last", 32'(bh[F]), 1);
    chk("a5_busy_fall", 32'(bh[F + 1]), 0);
`ifdef UART_TX_PARITY_EN
    push_one(8'h07);
    for (int i = 1; i <= F + 4; i++) begin
      tick();
      hist[i] = tx;
      bh[i] = busy;
    end
    for (int j = 0; j < C; j++) chk("par_bit", 32'(hist[2 + C * 9 + j]), 32'(1'b1 ^ ODD));
    for (int j = 0; j < 2 * C; j++) chk("par_stop", 32'(hist[2 + C * 10 + j]), 1);
    chk("par_busy_last", 32'(bh[F]), 1);
    chk("par_busy_fall", 32'(bh[F + 1]), 0);
`endif
    push_one(8'h11);
    tick();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1;
      data = burst[i];
      if (i == 4) begin
        chk("ready_5th", 32'(ready), 0);
        chk("level_full", 32'(level), 4);
      end else chk("ready_burst", 32'(ready), 1);
      tick();
    end
    valid = 1'b0;
    for (int i = 0; i < 300 && !ready; i++) tick();
    chk("ready_rise", 32'(ready), 1);
    push_one(8'h55);
    drain();
    push_one(8'h3A);
    push_one(8'hC6);
    for (int i = 0; i < 300 && !(m_act && m_word == 8'hC6 && cyc == m_s + 17); i++) tick();
    chk("frame2_bit3_line", 32'(tx), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_tx", 32'(tx), 1);
    chk("rst_level", 32'(level), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(ready), 1);
    for (int i = 0; i < 3 * F; i++) tick();
    chk("rst_no_restart", 32'(busy), 0);
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1;
      data = 8'h40 + 8'(i);
      tick();
    end
    data = 8'h99;
    chk("full_level", 32'(level), 4);
    chk("full_ready", 32'(ready), 0);
    for (int i = 0; i < 200 && cyc != m_s + F - 1; i++) tick();
    chk("full_before_pop", 32'(level), 4);
    tick();
    chk("pop_level", 32'(level), 3);
    chk("pop_ready", 32'(ready), 1);
    tick();
    chk("repush_level", 32'(level), 4);
    valid = 1'b0;
    drain();
    for (int i = 0; i < 3000; i++) begin
      valid = $urandom_range(0, 7) == 0;
      data = 8'($urandom);
      rst = $urandom_range(0, 999) == 0;
      tick();
    end
    rst = 1'b0;
    valid = 1'b0;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
